mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed, little-endian data-memory port: drives address, writeData, memRead and memWrite, and reads memData.
- Sits between the multicycle RISC-V datapath and the memory. Accepts one load/store request at a time over a valid/ready handshake.
- Performs RV32I lb/lh/lw/lbu/lhu/sb/sh/sw. Sub-word stores are done as a read-modify-write of the containing aligned word.
- Returns sign/zero-extended load data, or an error for misaligned, out-of-range or illegal requests.

Parameters:
MEM_BYTES, 256, memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
ADDR_W, 32, address width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used for sb/sh)
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid; request was rejected
resp_rdata  output  32  extended load data; 0 for stores and errors
address  output  32  memory address, always word-aligned
writeData  output  32  memory write word
memRead  output  1  memory read enable (memory read is combinational)
memWrite  output  1  memory write enable (memory commits at posedge)
memData  input  32  memory read word

Behaviour:
- States: IDLE, LOAD, RMW_RD, RMW_WR, STORE, RESP.
- Reset (reset=0, async):
  - State goes to IDLE; all registers clear.
  - req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, memRead=0, memWrite=0, address=0, writeData=0.
  - Reset asserted mid-operation aborts the operation immediately. No memWrite may be asserted after reset falls; the memory is left unchanged if RMW_WR had not yet been reached.
- req_ready = (state==IDLE) && reset. A request is accepted on a posedge with req_valid && req_ready; all req_* fields are captured into registers then. req_* inputs are ignored at all other times.
- Decode at acceptance, in this priority:
  - Illegal funct3 → error. Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Misaligned → error: lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=0.
  - Out of range → error: (addr & ~3) > MEM_BYTES-4.
  - An error goes straight to RESP with resp_err=1 and no memory access.
- Memory outputs:
  - Every memory cycle drives address = captured addr & ~3.
  - memRead=1 only in LOAD and RMW_RD. memWrite=1 only in STORE and RMW_WR. memRead and memWrite are never both 1.
  - In all other states, memory outputs are 0.
- LOAD (1 cycle): sample memData at the posedge leaving LOAD.
  - Byte: extract lane addr[1:0] (bits 8*k+7:8*k).
  - Half: extract lane addr[1] (bits 16*h+15:16*h).
  - Extend: lb/lh sign-extend, lbu/lhu zero-extend. Go to RESP.
- STORE (sw, 1 cycle): writeData=wdata, memWrite=1. Go to RESP.
- RMW_RD (sb/sh): capture memData. RMW_WR: writeData = captured word with the target byte/half replaced by wdata[7:0]/wdata[15:0], memWrite=1. Go to RESP.
- RESP (1 cycle): resp_valid=1, with resp_err and resp_rdata registered. Next state IDLE.
- Latency from acceptance edge to resp_valid cycle:
  - load: 2
  - sw: 2
  - sb/sh: 3
  - error: 1
- Throughput: one request per latency+1 cycles; req_ready returns the cycle after RESP.
- resp_valid is never held longer than one cycle and there is no response backpressure. The consumer must sample it.

Decomposition:
- Package mem_access_pkg holds:
  - state enum
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - localparam for the byte-lane mask
- One natural combinational sub-module, mem_lane_align. It does:
  - load extraction and extension (word, addr[1:0], funct3 → rdata)
  - store merge (old word, wdata, addr[1:0], funct3 → new word)

Test Plan:
- Memory word at 0x10 = 0x8844_22F1. Loads then give:
  - lb 0x10 → 0xFFFF_FFF1
  - lbu 0x10 → 0x0000_00F1
  - lh 0x12 → 0xFFFF_8844
  - lw 0x10 → 0x8844_22F1
  - each with resp_err=0 and resp_valid exactly 2 cycles after acceptance.
- sb 0x11 with wdata=0x0000_00AB on word 0x8844_22F1: expect memRead then memWrite with writeData=0x8844_ABF1, resp 3 cycles after acceptance. A following lw 0x10 returns 0x8844_ABF1.
- sw 0x20 with 0xDEAD_BEEF → single memWrite cycle at address 0x20, resp after 2 cycles; lw 0x20 returns 0xDEAD_BEEF.
- Error cases each give resp_err=1 after 1 cycle, memRead=memWrite=0 throughout, and resp_rdata=0:
  - lw 0x13
  - sh 0x21
  - funct3=011
  - lw 0xFC with MEM_BYTES=256 (legal, passes)
  - lw 0x100
- Assert reset=0 during RMW_RD of sb 0x30: outputs are zero immediately, no memWrite occurs, word 0x30 is unchanged, and after release req_ready=1 and a new request completes normally.
- Back-to-back: hold req_valid=1 with 3 loads queued by the bench. Each is accepted only when req_ready=1, responses arrive in order, and there is never more than one request in flight.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit.
// State encoding, RV32I load/store funct3 codes and the byte-lane mask.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    STORE  = 3'd4,
    RESP   = 3'd5
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Low address bits selecting a byte within a word.
  localparam logic [1:0] LANE_MASK = 2'b11;

  function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response port from the datapath and the initiator-side memory bus.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a single-cycle pulse with no backpressure.
interface mem_req_if #(parameter int ADDR_W = 32) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface mem_bus_if #(parameter int ADDR_W = 32) ();
  logic [ADDR_W-1:0] address;
  logic [31:0]       writeData;
  logic              memRead;
  logic              memWrite;
  logic [31:0]       memData;

  modport master (
    output address, writeData, memRead, memWrite,
    input  memData
  );

  modport slave (
    input  address, writeData, memRead, memWrite,
    output memData
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends load data, and merges
// sub-word store data into the old word for read-modify-write.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [31:0] st_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word_i[8*offset_i +: 8];
  assign ld_half = ld_word_i[16*offset_i[1] +: 16];

  always_comb begin
    ld_data_o = '0;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'b0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'b0, ld_half};
      F3_W:    ld_data_o = ld_word_i;
      default: ld_data_o = '0;
    endcase
  end

  always_comb begin
    st_word_o = st_word_i;
    case (funct3_i)
      F3_B:    st_word_o[8*offset_i +: 8]       = wdata_i[7:0];
      F3_H:    st_word_o[16*offset_i[1] +: 16]  = wdata_i[15:0];
      F3_W:    st_word_o                        = wdata_i;
      default: st_word_o                        = st_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the multicycle datapath and a word-wide memory.
// One request in flight; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  mem_req_if.slave   req_if,
  mem_bus_if.master  bus_if,
  output state_e     dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] req_aligned;
  logic [ADDR_W-1:0] cur_aligned;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  assign req_aligned = req_if.req_addr & ~ADDR_W'(LANE_MASK);
  assign cur_aligned = addr_q & ~ADDR_W'(LANE_MASK);
  assign dbg_state_o = state_q;

  always_comb begin
    misaligned = 1'b0;
    case (req_if.req_funct3)
      F3_H, F3_HU: misaligned = req_if.req_addr[0];
      F3_W:        misaligned = (req_if.req_addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (req_aligned > ADDR_W'(MEM_BYTES - 4));
  assign req_err      = !f3_legal(req_if.req_write, req_if.req_funct3) || misaligned || out_of_range;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign req_if.req_ready = (state_q == IDLE) && reset;
  assign accept           = req_if.req_valid && req_if.req_ready;

  mem_lane_align u_align (
    .ld_word_i (bus_if.memData),
    .st_word_i (word_q),
    .wdata_i   (wdata_q),
    .offset_i  (addr_q[1:0] & LANE_MASK),
    .funct3_i  (funct3_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    funct3_d             = funct3_q;
    wdata_d              = wdata_q;
    word_d               = word_q;
    rdata_d              = rdata_q;
    err_d                = err_q;
    bus_if.address       = '0;
    bus_if.writeData     = '0;
    bus_if.memRead       = 1'b0;
    bus_if.memWrite      = 1'b0;
    req_if.resp_valid    = 1'b0;
    req_if.resp_err      = 1'b0;
    req_if.resp_rdata    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_if.req_addr;
          funct3_d = req_if.req_funct3;
          wdata_d  = req_if.req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err)                           state_d = RESP;
          else if (!req_if.req_write)            state_d = LOAD;
          else if (req_if.req_funct3 == F3_W)    state_d = STORE;
          else                                   state_d = RMW_RD;
        end
      end
      LOAD: begin
        bus_if.address = cur_aligned;
        bus_if.memRead = 1'b1;
        rdata_d        = ld_data;
        state_d        = RESP;
      end
      RMW_RD: begin
        bus_if.address = cur_aligned;
        bus_if.memRead = 1'b1;
        word_d         = bus_if.memData;
        state_d        = RMW_WR;
      end
      RMW_WR: begin
        bus_if.address   = cur_aligned;
        bus_if.writeData = st_word;
        bus_if.memWrite  = 1'b1;
        state_d          = RESP;
      end
      STORE: begin
        bus_if.address   = cur_aligned;
        bus_if.writeData = wdata_q;
        bus_if.memWrite  = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        req_if.resp_valid = 1'b1;
        req_if.resp_err   = err_q;
        req_if.resp_rdata = rdata_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural memory.
// Each task drives one scenario and checks its own hand-computed results.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_req_if #(.ADDR_W(32)) rq ();
  mem_bus_if #(.ADDR_W(32)) bus ();
  state_e dbg_state;

  mem_access_unit #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (rq),
    .bus_if      (bus),
    .dbg_state_o (dbg_state)
  );

  logic [31:0] mem [0:63];
  logic        poke_en  = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          overlap  = 0;

  assign bus.memData = mem[bus.address[7:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.memWrite) mem[bus.address[7:2]] <= bus.writeData;
  end

  always @(negedge clk) if (bus.memRead && bus.memWrite) overlap++;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int n_rd, output int n_wr, output logic [31:0] wr_data, output logic [31:0] wr_addr);
    int guard;
    rdata = '0; err = 1'b0; lat = 0; n_rd = 0; n_wr = 0; wr_data = '0; wr_addr = '0; guard = 0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_write = w; rq.req_funct3 = f3; rq.req_addr = a; rq.req_wdata = wd;
    while (!rq.req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    rq.req_valid = 1'b0;
    lat = 1;
    while (!rq.resp_valid && lat < 10) begin
      if (bus.memRead) n_rd++;
      if (bus.memWrite) begin n_wr++; wr_data = bus.writeData; wr_addr = bus.address; end
      @(negedge clk);
      lat++;
    end
    rdata = rq.resp_rdata;
    err   = rq.resp_err;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({rq.req_ready, rq.resp_valid, rq.resp_err, bus.memRead, bus.memWrite} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b, want 00000",
        {rq.req_ready, rq.resp_valid, rq.resp_err, bus.memRead, bus.memWrite});
    end
    n_cmp++;
    if ({rq.resp_rdata, bus.address, bus.writeData} !== 96'b0) begin
      n_bad++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, want all 0",
        rq.resp_rdata, bus.address, bus.writeData);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d, want IDLE", dbg_state); end
    poke(6'd4, 32'h8844_22F1);
    poke(6'd8, 32'h0000_0000);
    poke(6'd12, 32'hCAFE_F00D);
    poke(6'd63, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rq.req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b, want 1", rq.req_ready); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_W};
    logic [31:0] adrs [4] = '{32'h10, 32'h10, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8844, 32'h8844_22F1};
    logic [31:0] rd, wdo, wao; logic er; int lat, nr, nw;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, nr, nw, wdo, wao);
      n_cmp++;
      if (rd !== exps[i]) begin n_bad++; $display("FAIL load%0d_data: got %h, want %h", i, rd, exps[i]); end
      n_cmp++;
      if ({er, lat[3:0]} !== {1'b0, 4'd2}) begin
        n_bad++; $display("FAIL load%0d_timing: err=%b lat=%0d, want err=0 lat=2", i, er, lat);
      end
      n_cmp++;
      if (nr !== 1 || nw !== 0) begin
        n_bad++; $display("FAIL load%0d_bus: reads=%0d writes=%0d, want 1/0", i, nr, nw);
      end
    end
  endtask

  task automatic test_sub_word_store;
    logic [31:0] rd, wdo, wao; logic er; int lat, nr, nw;
    issue(1'b1, F3_B, 32'h11, 32'h0000_00AB, rd, er, lat, nr, nw, wdo, wao);
    n_cmp++;
    if (wdo !== 32'h8844_ABF1 || wao !== 32'h10) begin
      n_bad++; $display("FAIL sb_merge: wdata=%h addr=%h, want 8844abf1 @ 10", wdo, wao);
    end
    n_cmp++;
    if (lat !== 3 || nr !== 1 || nw !== 1 || er !== 1'b0 || rd !== 32'h0) begin
      n_bad++; $display("FAIL sb_timing: lat=%0d rd=%0d wr=%0d err=%b rdata=%h, want 3/1/1/0/0", lat, nr, nw, er, rd);
    end
    issue(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat, nr, nw, wdo, wao);
    n_cmp++;
    if (rd !== 32'h8844_ABF1) begin n_bad++; $display("FAIL sb_readback: got %h, want 8844abf1", rd); end
  endtask

  task automatic test_word_store;
    logic [31:0] rd, wdo, wao; logic er; int lat, nr, nw;
    issue(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, rd, er, lat, nr, nw, wdo, wao);
    n_cmp++;
    if (wdo !== 32'hDEAD_BEEF || wao !== 32'h20) begin
      n_bad++; $display("FAIL sw_write: wdata=%h addr=%h, want deadbeef @ 20", wdo, wao);
    end
    n_cmp++;
    if (lat !== 2 || nr !== 0 || nw !== 1 || er !== 1'b0 || rd !== 32'h0) begin
      n_bad++; $display("FAIL sw_timing: lat=%0d rd=%0d wr=%0d err=%b rdata=%h, want 2/0/1/0/0", lat, nr, nw, er, rd);
    end
    issue(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat, nr, nw, wdo, wao);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_readback: got %h, want deadbeef", rd); end
  endtask

  task automatic test_errors;
    logic        ws   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s  [4] = '{F3_W, F3_H, 3'b011, F3_W};
    logic [31:0] adrs [4] = '{32'h13, 32'h21, 32'h0, 32'h100};
    logic [31:0] rd, wdo, wao; logic er; int lat, nr, nw;
    for (int i = 0; i < 4; i++) begin
      issue(ws[i], f3s[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat, nr, nw, wdo, wao);
      n_cmp++;
      if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || nr !== 0 || nw !== 0) begin
        n_bad++; $display("FAIL err%0d: err=%b lat=%0d rdata=%h rd=%0d wr=%0d, want 1/1/0/0/0", i, er, lat, rd, nr, nw);
      end
    end
    issue(1'b0, F3_W, 32'hFC, 32'h0, rd, er, lat, nr, nw, wdo, wao);
    n_cmp++;
    if (er !== 1'b0 || lat !== 2 || rd !== 32'h1234_5678) begin
      n_bad++; $display("FAIL top_word: err=%b lat=%0d rdata=%h, want 0/2/12345678", er, lat, rd);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, wdo, wao; logic er; int lat, nr, nw, writes, guard;
    writes = 0; guard = 0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_write = 1'b1; rq.req_funct3 = F3_B; rq.req_addr = 32'h30; rq.req_wdata = 32'h55;
    while (!rq.req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    rq.req_valid = 1'b0;
    n_cmp++;
    if (dbg_state !== RMW_RD || bus.memRead !== 1'b1) begin
      n_bad++; $display("FAIL abort_setup: state=%0d memRead=%b, want RMW_RD/1", dbg_state, bus.memRead);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.memRead, bus.memWrite, rq.req_ready, rq.resp_valid, rq.resp_err} !== 5'b0 ||
        {bus.address, bus.writeData, rq.resp_rdata} !== 96'b0) begin
      n_bad++; $display("FAIL abort_outputs: ctrl=%b addr=%h wdata=%h rdata=%h, want all 0",
        {bus.memRead, bus.memWrite, rq.req_ready, rq.resp_valid, rq.resp_err}, bus.address, bus.writeData, rq.resp_rdata);
    end
    repeat (3) begin @(negedge clk); if (bus.memWrite) writes++; end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rq.req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b, want 1", rq.req_ready); end
    repeat (2) begin @(negedge clk); if (bus.memWrite) writes++; end
    n_cmp++;
    if (writes !== 0 || mem[12] !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL abort_mem: writes=%0d word=%h, want 0 / cafef00d", writes, mem[12]);
    end
    issue(1'b0, F3_W, 32'h30, 32'h0, rd, er, lat, nr, nw, wdo, wao);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 2) begin
      n_bad++; $display("FAIL abort_recover: rdata=%h err=%b lat=%0d, want cafef00d/0/2", rd, er, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ba [3] = '{32'h10, 32'h13, 32'h20};
    logic [2:0]  bf [3] = '{F3_H, F3_BU, F3_W};
    logic [31:0] be [3] = '{32'hFFFF_ABF1, 32'h0000_0088, 32'hDEAD_BEEF};
    int idx, inflight, got, cyc; logic pending; logic [31:0] e;
    idx = 0; inflight = 0; got = 0; cyc = 0; pending = 1'b0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_funct3 = bf[0]; rq.req_addr = ba[0]; rq.req_wdata = '0;
    while (got < 3 && cyc < 60) begin
      if (rq.resp_valid) begin
        inflight--; got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_unexpected: rdata=%h with no request pending", rq.resp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rq.resp_rdata !== e || rq.resp_err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_resp%0d: rdata=%h err=%b, want %h/0", got, rq.resp_rdata, rq.resp_err, e);
          end
        end
      end
      if (pending) begin
        pending = 1'b0; idx++;
        if (idx < 3) begin rq.req_funct3 = bf[idx]; rq.req_addr = ba[idx]; end
        else rq.req_valid = 1'b0;
      end
      if (rq.req_valid && rq.req_ready) begin
        pending = 1'b1; inflight++;
        exp_q.push_back(be[idx]);
        n_cmp++;
        if (inflight !== 1) begin n_bad++; $display("FAIL b2b_inflight: got %0d, want 1", inflight); end
      end
      @(negedge clk);
      cyc++;
    end
    rq.req_valid = 1'b0;
    n_cmp++;
    if (got !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d responses, want 3", got); end
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (overlap !== 0) begin n_bad++; $display("FAIL rd_wr_overlap: got %0d cycles, want 0", overlap); end
  endtask

  initial begin
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_funct3 = '0; rq.req_addr = '0; rq.req_wdata = '0;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_word_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_bad);
    $fatal(1);
  end

endmodule
